// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_pkg                                                 |
// | Brief    : Shared ALU constants and the divider inter-stage bundle |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package alu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;

  // quo starts as |dividend| and trades one dividend digit for one quotient digit per stage
  typedef struct packed {
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dsr;
    logic            neg_q;
    logic            neg_r;
    logic            dz;
  } div_bundle_t;
endpackage
`default_nettype wire

// File: rtl/radix4_unrolled_divider_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : radix4_unrolled_divider_if                              |
// | Brief    : Operand/result bundle for the radix-4 divider           |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface radix4_unrolled_divider_if
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
);
  logic             in_valid;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (output in_valid, dividend, divisor,
                  input  out_valid, quotient, remainder);
  modport slave  (input  in_valid, dividend, divisor,
                  output out_valid, quotient, remainder);
endinterface
`default_nettype wire

// File: rtl/div_radix4_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : div_radix4_stage                                        |
// | Brief    : One combinational radix-4 restoring digit step          |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module div_radix4_stage #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] rem_in,
  input  wire logic [WIDTH-1:0] quo_in,
  input  wire logic [WIDTH-1:0] dsr,
  output logic      [WIDTH-1:0] rem_out,
  output logic      [WIDTH-1:0] quo_out
);
  logic [WIDTH+1:0] pr;
  logic [WIDTH+1:0] d1;
  logic [WIDTH+1:0] d2;
  logic [WIDTH+1:0] d3;
  logic [WIDTH+1:0] diff;
  logic [1:0]       digit;
  logic [1:0]       unused_diff_hi;

  always_comb begin
    pr    = {rem_in, quo_in[WIDTH-1 -: 2]};
    d1    = {2'b00, dsr};
    d2    = {1'b0, dsr, 1'b0};
    d3    = d1 + d2;
    digit = 2'd0;
    diff  = pr;
    if (pr >= d3) begin
      digit = 2'd3;
      diff  = pr - d3;
    end else if (pr >= d2) begin
      digit = 2'd2;
      diff  = pr - d2;
    end else if (pr >= d1) begin
      digit = 2'd1;
      diff  = pr - d1;
    end
    // With a nonzero divisor the new remainder is below d, so it fits WIDTH bits
    rem_out = diff[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-3:0], digit};
  end

  assign unused_diff_hi = diff[WIDTH+1:WIDTH];
endmodule
`default_nettype wire

// File: rtl/radix4_unrolled_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : radix4_unrolled_divider                                 |
// | Brief    : Signed DIV/MOD, 16 unrolled radix-4 stages, registered  |
// |            result. Define DIV_MIDPIPE_EN for a mid-chain bank.     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module radix4_unrolled_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input wire logic                  clk,
  input wire logic                  rst,
  radix4_unrolled_divider_if.slave  bus
);
  localparam int NSTAGE = WIDTH / 2;
  localparam int SPLIT  = NSTAGE / 2;

  div_bundle_t      front;
  div_bundle_t      fin;
  logic             fin_valid;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             unused_dsr;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

`ifdef DIV_MIDPIPE_EN
  div_bundle_t      mid_q, mid_d;
  logic             mid_valid_q, mid_valid_d;
`endif

  always_comb begin
    front       = '0;
    front.neg_r = bus.dividend[WIDTH-1];
    front.neg_q = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
    front.dz    = (bus.divisor == '0);
    front.quo   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    front.dsr   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  end

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    div_bundle_t      src;
    div_bundle_t      dst;
    logic [WIDTH-1:0] rem_o;
    logic [WIDTH-1:0] quo_o;

    if (i == 0) begin : g_first
      assign src = front;
    end else if (i == SPLIT) begin : g_split
`ifdef DIV_MIDPIPE_EN
      assign src = mid_q;
`else
      assign src = g_stage[i-1].dst;
`endif
    end else begin : g_thru
      assign src = g_stage[i-1].dst;
    end

    div_radix4_stage #(.WIDTH(WIDTH)) u_stage (
      .rem_in  (src.rem),
      .quo_in  (src.quo),
      .dsr     (src.dsr),
      .rem_out (rem_o),
      .quo_out (quo_o)
    );

    always_comb begin
      dst     = src;
      dst.rem = rem_o;
      dst.quo = quo_o;
    end
  end

`ifdef DIV_MIDPIPE_EN
  always_comb begin
    mid_valid_d = bus.in_valid;
    mid_d       = mid_q;
    if (bus.in_valid) begin
      mid_d = g_stage[SPLIT-1].dst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_valid_q <= 1'b0;
      mid_q       <= '0;
    end else begin
      mid_valid_q <= mid_valid_d;
      mid_q       <= mid_d;
    end
  end

  assign fin_valid = mid_valid_q;
`else
  assign fin_valid = bus.in_valid;
`endif

  assign fin        = g_stage[NSTAGE-1].dst;
  assign unused_dsr = ^fin.dsr;

  // A zero divisor leaves all dividend bits shifted into rem, so r_res restores the dividend
  always_comb begin
    q_res = fin.neg_q ? -fin.quo : fin.quo;
    if (fin.dz) begin
      q_res = DIV_BY_ZERO_Q;
    end
    r_res = fin.neg_r ? -fin.rem : fin.rem;
  end

  always_comb begin
    out_valid_d = fin_valid;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (fin_valid) begin
      quotient_d  = q_res;
      remainder_d = r_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
endmodule
`default_nettype wire

// File: tb/tb_radix4_unrolled_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_radix4_unrolled_divider                              |
// | Brief    : Directed and back-to-back checks of the radix-4 divider |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_radix4_unrolled_divider;
`ifdef DIV_MIDPIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  radix4_unrolled_divider_if #(.WIDTH(32)) bus ();

  radix4_unrolled_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: out_valid=%b q=%h r=%h, required 0/0/0",
               bus.out_valid, bus.quotient, bus.remainder);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    vec_t        tbl [15];
    logic [31:0] prev_q;
    logic [31:0] prev_r;
    tbl[0]  = '{32'd10,       32'd2,        32'd5,        32'd0};
    tbl[1]  = '{32'hFFFFFFF6, 32'd2,        32'hFFFFFFFB, 32'd0};
    tbl[2]  = '{32'd10,       32'd3,        32'd3,        32'd1};
    tbl[3]  = '{32'hFFFFFFF6, 32'd3,        32'hFFFFFFFD, 32'hFFFFFFFF};
    tbl[4]  = '{32'd10,       32'hFFFFFFFD, 32'hFFFFFFFD, 32'd1};
    tbl[5]  = '{32'd10,       32'd0,        32'hFFFFFFFF, 32'd10};
    tbl[6]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    tbl[7]  = '{32'd0,        32'd7,        32'd0,        32'd0};
    tbl[8]  = '{32'd5,        32'hFFFFFFF7, 32'd0,        32'd5};
    tbl[9]  = '{32'hFFFFFFF9, 32'd7,        32'hFFFFFFFF, 32'd0};
    tbl[10] = '{32'h80000000, 32'd0,        32'hFFFFFFFF, 32'h80000000};
    tbl[11] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0};
    tbl[12] = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0};
    tbl[13] = '{32'd100,      32'd7,        32'd14,       32'd2};
    tbl[14] = '{32'h80000001, 32'h80000000, 32'd0,        32'h80000001};
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = tbl[i].a;
      bus.divisor  = tbl[i].b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = 32'h1234_5678;
      bus.divisor  = 32'd3;
      repeat (LAT - 1) begin
        @(posedge clk);
        #1;
      end
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.quotient !== tbl[i].q || bus.remainder !== tbl[i].r) begin
        miscompares++;
        $display("FAIL directed[%0d] %h/%h: valid=%b q=%h r=%h, required 1 q=%h r=%h",
                 i, tbl[i].a, tbl[i].b, bus.out_valid, bus.quotient, bus.remainder,
                 tbl[i].q, tbl[i].r);
      end
      prev_q = tbl[i].q;
      prev_r = tbl[i].r;
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.quotient !== prev_q || bus.remainder !== prev_r) begin
        miscompares++;
        $display("FAIL hold[%0d]: valid=%b q=%h r=%h, required 0 q=%h r=%h",
                 i, bus.out_valid, bus.quotient, bus.remainder, prev_q, prev_r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        sv [LAT];
    logic [31:0] sq [LAT];
    logic [31:0] sr [LAT];
    logic [31:0] hq;
    logic [31:0] hr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        iv;
    logic        rs;
    for (int k = 0; k < LAT; k++) begin
      sv[k] = 1'b0;
      sq[k] = 32'd0;
      sr[k] = 32'd0;
    end
    hq = 32'd0;
    hr = 32'd0;
    for (int c = 0; c < 200; c++) begin
      rs = (c == 0) || (c == 90) || (c == 91) || (c == 150);
      iv = ($urandom_range(0, 3) != 0);
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 9));
        3:       b = -32'($urandom_range(1, 9));
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h80000000;
      rst          = rs;
      bus.in_valid = iv;
      bus.dividend = a;
      bus.divisor  = b;
      ref_div(a, b, eq, er);
      @(posedge clk);
      if (rs) begin
        for (int k = 0; k < LAT; k++) sv[k] = 1'b0;
        hq = 32'd0;
        hr = 32'd0;
      end else begin
        for (int k = LAT - 1; k > 0; k--) begin
          sv[k] = sv[k-1];
          sq[k] = sq[k-1];
          sr[k] = sr[k-1];
        end
        sv[0] = iv;
        sq[0] = eq;
        sr[0] = er;
        if (sv[LAT-1]) begin
          hq = sq[LAT-1];
          hr = sr[LAT-1];
        end
      end
      #1;
      vectors++;
      if (bus.out_valid !== (sv[LAT-1] && !rs)) begin
        miscompares++;
        $display("FAIL b2b_valid cycle %0d: got %b, required %b",
                 c, bus.out_valid, sv[LAT-1] && !rs);
      end
      vectors++;
      if (bus.quotient !== hq) begin
        miscompares++;
        $display("FAIL b2b_quotient cycle %0d: got %h, required %h", c, bus.quotient, hq);
      end
      vectors++;
      if (bus.remainder !== hr) begin
        miscompares++;
        $display("FAIL b2b_remainder cycle %0d: got %h, required %h", c, bus.remainder, hr);
      end
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
